// File: rtl/alu32_result_buffer_pkg.sv
// Shared types for the ALU result buffer: buffer state encoding, default widths
// and the state-to-occupancy mapping.
package alu32_result_buffer_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned DLV_CNT_W = 16;
  localparam int unsigned LEVEL_W   = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // The state encoding doubles as the occupancy count.
  function automatic logic [LEVEL_W-1:0] level_of(input buf_state_e s);
    return LEVEL_W'(s);
  endfunction

endpackage

// File: rtl/alu32_result_buffer_if.sv
// Upstream/downstream handshake bundle of the ALU result buffer; the slave
// modport is the buffer's view, the master modport the surrounding pipeline's.
interface alu32_result_buffer_if
  import alu32_result_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = DLV_CNT_W
);

  logic               in_vld;
  logic               in_rdy;
  logic [WIDTH-1:0]   in_dat;
  logic               in_carry;
  logic               out_vld;
  logic               out_rdy;
  logic [WIDTH-1:0]   out_dat;
  logic               out_zero;
  logic               out_neg;
  logic               out_carry;
  logic [LEVEL_W-1:0] level;
  logic [CNT_W-1:0]   delivered;

  modport slave (
    input  in_vld, in_dat, in_carry, out_rdy,
    output in_rdy, out_vld, out_dat, out_zero, out_neg, out_carry, level, delivered
  );

  modport master (
    output in_vld, in_dat, in_carry, out_rdy,
    input  in_rdy, out_vld, out_dat, out_zero, out_neg, out_carry, level, delivered
  );

endinterface

// File: rtl/alu32_result_buffer_flag_gen.sv
// Combinational zero/negative flags of a result word; no state, no latency,
// no backpressure.
module alu32_flag_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_dat,
  output logic             o_zero,
  output logic             o_neg
);

  assign o_zero = (i_dat == '0);
  assign o_neg  = i_dat[WIDTH-1];

endmodule

// File: rtl/alu32_result_buffer.sv
// Two-entry skid buffer for ALU results with capture-time flags; 1-cycle latency.
// Backpressure: in_rdy is registered (low only when full), never combinational from out_rdy.
module alu32_result_buffer
  import alu32_result_buffer_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned CNT_W = DLV_CNT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  alu32_result_buffer_if.slave  bus
);

  typedef struct packed {
    logic [WIDTH-1:0] dat;
    logic             zero;
    logic             neg;
    logic             carry;
  } entry_t;

  buf_state_e       r_state;
  buf_state_e       w_state_nxt;
  entry_t           r_head;
  entry_t           r_skid;
  entry_t           w_in_entry;
  logic             r_in_rdy;
  logic [CNT_W-1:0] r_delivered;

  logic w_zero;
  logic w_neg;
  logic w_out_vld;
  logic w_push;
  logic w_pop;
  logic w_load_head;
  logic w_head_from_skid;
  logic w_load_skid;

  alu32_flag_gen #(
    .WIDTH (WIDTH)
  ) u_flag_gen (
    .i_dat  (bus.in_dat),
    .o_zero (w_zero),
    .o_neg  (w_neg)
  );

  assign w_in_entry = '{dat: bus.in_dat, zero: w_zero, neg: w_neg, carry: bus.in_carry};

  assign w_out_vld = (r_state != ST_EMPTY);
  assign w_push    = bus.in_vld & r_in_rdy;
  assign w_pop     = w_out_vld & bus.out_rdy;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_head      = 1'b0;
    w_head_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_push) begin
          w_state_nxt = ST_ONE;
          w_load_head = 1'b1;
        end
      end
      ST_ONE: begin
        // With a simultaneous pop the new result bypasses the skid slot.
        if (w_push && w_pop) begin
          w_load_head = 1'b1;
        end else if (w_push) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_pop) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_pop) begin
          w_state_nxt      = ST_ONE;
          w_head_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_EMPTY;
      r_in_rdy    <= 1'b0;
      r_head      <= '0;
      r_skid      <= '0;
      r_delivered <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_rdy <= (w_state_nxt != ST_TWO);
      if (w_load_head) begin
        r_head <= w_in_entry;
      end else if (w_head_from_skid) begin
        r_head <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_in_entry;
      end
      if (w_pop) begin
        r_delivered <= r_delivered + CNT_W'(1);
      end
    end
  end

  assign bus.in_rdy    = r_in_rdy;
  assign bus.out_vld   = w_out_vld;
  assign bus.out_dat   = r_head.dat;
  assign bus.out_zero  = r_head.zero;
  assign bus.out_neg   = r_head.neg;
  assign bus.out_carry = r_head.carry;
  assign bus.level     = level_of(r_state);
  assign bus.delivered = r_delivered;

endmodule

// File: tb/tb_alu32_result_buffer.sv
// Bench for alu32_result_buffer: queue-based reference model compared every cycle,
// plus directed literal expectations.
module tb_alu32_result_buffer;

  typedef struct packed {
    logic [31:0] dat;
    logic        zero;
    logic        neg;
    logic        carry;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  alu32_result_buffer_if #(.WIDTH(32), .CNT_W(16)) bus ();

  alu32_result_buffer #(
    .WIDTH (32),
    .CNT_W (16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: a plain FIFO of at most two results.
  ent_t        q[$];
  logic        m_rdy    = 1'b0;
  logic [15:0] m_dlv    = 16'd0;
  int          m_pushes = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        m_rdy = 1'b0;
        m_dlv = 16'd0;
      end else begin
        logic do_push;
        logic do_pop;
        do_push = bus.in_vld && m_rdy;
        do_pop  = (q.size() > 0) && bus.out_rdy;
        if (do_pop) begin
          void'(q.pop_front());
          m_dlv = m_dlv + 16'd1;
        end
        if (do_push) begin
          q.push_back('{dat: bus.in_dat, zero: (bus.in_dat == 32'd0),
                        neg: bus.in_dat[31], carry: bus.in_carry});
          m_pushes++;
        end
        m_rdy = (q.size() < 2);
      end
    end
  end

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst) begin
      cmp("reset_outs",
          64'({bus.in_rdy, bus.out_vld, bus.out_dat, bus.out_zero, bus.out_neg,
               bus.out_carry, bus.level, bus.delivered}), 64'd0);
    end else begin
      cmp("m_in_rdy",    64'(bus.in_rdy), 64'(m_rdy));
      cmp("m_out_vld",   64'(bus.out_vld), 64'(q.size() > 0));
      cmp("m_level",     64'(bus.level), 64'(q.size()));
      cmp("m_delivered", 64'(bus.delivered), 64'(m_dlv));
      if (q.size() > 0) begin
        cmp("m_head",
            64'({bus.out_dat, bus.out_zero, bus.out_neg, bus.out_carry}), 64'(q[0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bus.in_vld   = 1'b1;
      bus.in_dat   = base + 32'(i);
      bus.in_carry = i[0];
      step();
    end
    bus.in_vld = 1'b0;
    step();
  endtask

  initial begin
    bus.in_vld   = 1'b0;
    bus.in_dat   = 32'd0;
    bus.in_carry = 1'b0;
    bus.out_rdy  = 1'b0;
    repeat (3) step();
    cmp("rdy_in_reset", 64'(bus.in_rdy), 64'd0);
    rst = 1'b0;
    step();
    cmp("rdy_after_rst", 64'(bus.in_rdy), 64'd1);

    // Zero word straight through
    bus.in_vld  = 1'b1;
    bus.in_dat  = 32'h0000_0000;
    bus.out_rdy = 1'b1;
    step();
    bus.in_vld = 1'b0;
    cmp("zero_vld",  64'(bus.out_vld), 64'd1);
    cmp("zero_flag", 64'(bus.out_zero), 64'd1);
    cmp("zero_neg",  64'(bus.out_neg), 64'd0);
    step();
    cmp("zero_dlv",  64'(bus.delivered), 64'd1);
    cmp("zero_lvl",  64'(bus.level), 64'd0);

    // Fill both entries with the consumer stalled
    bus.out_rdy  = 1'b0;
    bus.in_vld   = 1'b1;
    bus.in_dat   = 32'h8000_0001;
    bus.in_carry = 1'b1;
    step();
    bus.in_dat   = 32'h0000_0005;
    bus.in_carry = 1'b0;
    step();
    cmp("full_lvl",   64'(bus.level), 64'd2);
    cmp("full_rdy",   64'(bus.in_rdy), 64'd0);
    bus.in_dat = 32'hDEAD_BEEF;
    step();
    bus.in_vld = 1'b0;
    step();
    cmp("full_dat",   64'(bus.out_dat), 64'h8000_0001);
    cmp("full_neg",   64'(bus.out_neg), 64'd1);
    cmp("full_carry", 64'(bus.out_carry), 64'd1);
    cmp("full_lvl2",  64'(bus.level), 64'd2);

    // Drain in order
    bus.out_rdy = 1'b1;
    step();
    cmp("drain_dat", 64'(bus.out_dat), 64'h0000_0005);
    cmp("drain_lvl", 64'(bus.level), 64'd1);
    step();
    cmp("drain_lvl0", 64'(bus.level), 64'd0);
    cmp("drain_rdy",  64'(bus.in_rdy), 64'd1);
    cmp("drain_dlv",  64'(bus.delivered), 64'd3);

    // Asynchronous reset while full
    bus.out_rdy = 1'b0;
    stream(2, 32'h1234_0000);
    cmp("pre_rst_lvl", 64'(bus.level), 64'd2);
    #1;
    rst = 1'b1;
    #1;
    cmp("arst_vld", 64'(bus.out_vld), 64'd0);
    cmp("arst_lvl", 64'(bus.level), 64'd0);
    repeat (2) step();
    rst = 1'b0;
    step();
    cmp("rerst_rdy", 64'(bus.in_rdy), 64'd1);

    // Continuous streaming, one result per cycle
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_vld   = 1'b1;
      bus.in_dat   = 32'h0100_0000 + 32'(i * 7);
      bus.in_carry = i[1];
      step();
      cmp("stream_lvl", 64'(bus.level), 64'd1);
    end
    bus.in_vld = 1'b0;
    step();
    cmp("stream_dlv", 64'(bus.delivered), 64'd100);
    cmp("stream_lvl0", 64'(bus.level), 64'd0);

    // Counter wrap
    stream(65435, 32'hF000_0000);
    cmp("dlv_max", 64'(bus.delivered), 64'hFFFF);
    stream(1, 32'h7FFF_FFFF);
    cmp("dlv_wrap", 64'(bus.delivered), 64'h0000);

    // Irregular valid/ready pattern; the word is held until accepted
    for (int i = 0; i < 60; i++) begin
      bus.in_vld   = (i % 3) != 2;
      bus.out_rdy  = (i % 5) < 2;
      bus.in_dat   = 32'hA500_0000 + 32'(m_pushes);
      bus.in_carry = m_pushes[0];
      step();
    end
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (3) step();
    cmp("mix_lvl0", 64'(bus.level), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu32_result_buffer.md
ALU32_RESULT_BUFFER -- requirements
Module: alu32_result_buffer

Interface
REQ-001 Parameter WIDTH, 32, datapath width of the ALU result.
REQ-002 Parameter CNT_W, 16, width of the delivered-result counter.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 InValid  input  1  upstream ALU result valid.
REQ-006 InReady  output  1  buffer can accept a result this cycle.
REQ-007 InData  input  WIDTH  ALU result word (low-truncated/shifted output or any other ALU result).
REQ-008 InCarry  input  1  carry-out from the ALU operation.
REQ-009 OutValid  output  1  buffered result available.
REQ-010 OutReady  input  1  downstream consumer accepts the result.
REQ-011 OutData  output  WIDTH  head result word.
REQ-012 OutZero  output  1  head result equals zero.
REQ-013 OutNeg  output  1  head result bit WIDTH-1.
REQ-014 OutCarry  output  1  head result carry.
REQ-015 Level  output  2  occupancy, 0..2.
REQ-016 Delivered  output  CNT_W  count of results handed downstream.

Function
REQ-017 The block SHALL be a 2-entry skid buffer: head register (drives Out*) plus skid register.
REQ-018 The FSM SHALL have states EMPTY, ONE and TWO; Level SHALL equal 0, 1 and 2 respectively.
REQ-019 InReady SHALL be a registered signal, high exactly when the state is not TWO, with no combinational path from OutReady.
REQ-020 Push SHALL be InValid & InReady; pop SHALL be OutValid & OutReady.
REQ-021 Flags SHALL be computed at capture: Zero = (InData == 0), Neg = InData[WIDTH-1], Carry = InCarry; they SHALL be stored alongside the data.
REQ-022 Latency SHALL be 1 cycle: a result pushed at edge N SHALL appear on Out* with OutValid after edge N.
REQ-023 OutValid SHALL be high exactly when the state is ONE or TWO.
REQ-024 Transitions SHALL be as follows:
- EMPTY+push -> ONE (loads the head).
- ONE+push only -> TWO (loads the skid).
- ONE+pop only -> EMPTY.
- ONE+push+pop -> ONE (new result goes directly to the head).
- TWO+pop -> ONE (skid moves to the head).
- All other combinations SHALL hold the current state.
REQ-025 Out* SHALL remain stable while OutValid is high and OutReady is low.
REQ-026 Order SHALL be strict FIFO, with no loss or duplication under any InValid/OutReady pattern.
REQ-027 Delivered SHALL increment by 1 on each pop and SHALL wrap from 2^CNT_W-1 to 0.
REQ-028 InValid while InReady is low SHALL be ignored; the upstream SHALL hold its data.

Reset
REQ-029 While RST is high, the state SHALL be EMPTY and the outputs SHALL be: InReady=0, OutValid=0, OutData=0, OutZero=0, OutNeg=0, OutCarry=0, Level=0, Delivered=0.
REQ-030 InReady SHALL rise on the first edge after RST deasserts.
REQ-031 RST asserted mid-transfer SHALL discard all buffered entries immediately, with no partial pop.

Structure
REQ-032 State encodings (EMPTY=0, ONE=1, TWO=2) and default widths SHALL live in the shared alu32 package.
REQ-033 One sub-module alu32_flag_gen SHALL exist: combinational Zero/Neg from a WIDTH-bit word, instantiated once on the input path.

Verification
REQ-034 Reset release, InValid=1, InData=0x00000000, OutReady=1 -> OutValid the next cycle; OutZero=1, OutNeg=0, Delivered=1 after the pop.
REQ-035 Push 0x80000001 (InCarry=1), then 0x00000005, with OutReady=0 -> Level=2, InReady=0; head stays 0x80000001 with OutNeg=1 and OutCarry=1.
REQ-036 From REQ-035, OutReady=1 for two cycles -> outputs 0x80000001 then 0x00000005 in order; Level reaches 0 and InReady=1.
REQ-037 Continuous InValid with OutReady=1 -> one result per cycle at Level 1; 100 words in gives Delivered=100, all in order.
REQ-038 Preload Delivered to 0xFFFF via 65535 pops, then one more pop -> Delivered=0x0000.
REQ-039 RST pulse asserted while Level=2 -> OutValid=0 and Level=0 asynchronously, before the next clock edge.
